// File: rtl/pd_ram_arb_pkg.sv
// pd_ram_arb_pkg: shared defaults and types for the pd_block on-chip RAM arbiter.
package pd_ram_arb_pkg;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 32;
  localparam int NUM_REQ    = 2;

  // Requester id: 0 = host CPU data master, 1 = CNN engine load/store port.
  typedef logic req_id_t;

endpackage

// File: rtl/pd_ram_arb_pick.sv
// pd_ram_arb_pick: combinational one-hot grant picker for the two RAM requesters.
// Build option PD_RAM_ARB_RR_EN: when defined, a tie without a burst lock is broken
// round-robin (~last); when undefined, requester 0 has fixed priority and requester 1
// only gets in for one access after requester 0 has used up a full burst.
module pd_ram_arb_pick
  import pd_ram_arb_pkg::*;
#(
  parameter int MAX_BURST = 8,
  parameter int CNT_W     = 4
) (
  input  logic [NUM_REQ-1:0] r_i,
  input  logic               served_i,
  input  req_id_t            owner_i,
  input  logic [CNT_W-1:0]   cnt_i,
`ifdef PD_RAM_ARB_RR_EN
  input  req_id_t            last_i,
`endif
  output logic [NUM_REQ-1:0] grant_o
);

  req_id_t win;

  // Resolve who wins a tie, then map the request pattern onto a one-hot grant.
  always_comb begin
    win = 1'b0;
`ifdef PD_RAM_ARB_RR_EN
    // Owner keeps the RAM while its burst is still open, otherwise alternate.
    if (served_i && (cnt_i < CNT_W'(MAX_BURST))) win = owner_i;
    else                                         win = ~last_i;
`else
    // Requester 0 always wins unless it has just completed a full burst.
    if (served_i && (owner_i == 1'b0) && (cnt_i == CNT_W'(MAX_BURST))) win = 1'b1;
`endif
    case (r_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = win ? 2'b10 : 2'b01;
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/pd_block_ram_arbiter.sv
// pd_block_ram_arbiter: shares the single-port 4096x32 RAM between the host CPU
// (requester 0) and the CNN engine (requester 1). One access per clock, bounded
// burst ownership, read data routed back one cycle after acceptance.
// Build option PD_RAM_ARB_RR_EN selects round-robin tie-break (see pd_ram_arb_pick).
module pd_block_ram_arbiter
  import pd_ram_arb_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int BE_W      = DATA_W / 8,
  parameter int MAX_BURST = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ*ADDR_W-1:0] req_address,
  input  logic [NUM_REQ*BE_W-1:0]   req_byteenable,
  input  logic [NUM_REQ-1:0]        req_read,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*DATA_W-1:0] req_writedata,
  output logic [NUM_REQ-1:0]        req_waitrequest,
  output logic [DATA_W-1:0]         req_readdata,
  output logic [NUM_REQ-1:0]        req_readdatavalid,
  output logic [ADDR_W-1:0]         ram_address,
  output logic [BE_W-1:0]           ram_byteenable,
  output logic                      ram_chipselect,
  output logic                      ram_write,
  output logic [DATA_W-1:0]         ram_writedata,
  output logic                      ram_clken,
  input  logic [DATA_W-1:0]         ram_readdata
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  logic [NUM_REQ-1:0] req_any;
  logic [NUM_REQ-1:0] grant_raw;
  logic [NUM_REQ-1:0] grant;
  logic               gnt_vld;
  req_id_t            gnt_id;

  req_id_t            owner_q,   owner_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic               served_q,  served_d;
  logic               rd_pend_q, rd_pend_d;
  req_id_t            rd_id_q,   rd_id_d;
`ifdef PD_RAM_ARB_RR_EN
  req_id_t            last_q,    last_d;
`endif

  // A combined read+write counts as one request and is performed as a write.
  assign req_any = req_read | req_write;

  pd_ram_arb_pick #(
    .MAX_BURST (MAX_BURST),
    .CNT_W     (CNT_W)
  ) u_pick (
    .r_i      (req_any),
    .served_i (served_q),
    .owner_i  (owner_q),
    .cnt_i    (cnt_q),
`ifdef PD_RAM_ARB_RR_EN
    .last_i   (last_q),
`endif
    .grant_o  (grant_raw)
  );

  // While reset is held nothing is granted, which forces waitrequest high and idles the RAM.
  assign grant           = reset_n ? grant_raw : '0;
  assign gnt_vld         = |grant;
  assign gnt_id          = grant[1];
  assign req_waitrequest = ~grant;
  assign ram_clken       = 1'b1;

  // Route the granted requester's access onto the RAM port; park at zero when idle.
  always_comb begin
    ram_chipselect = gnt_vld;
    ram_write      = 1'b0;
    ram_address    = '0;
    ram_byteenable = '0;
    ram_writedata  = '0;
    if (gnt_vld) begin
      ram_write      = req_write[gnt_id];
      ram_address    = req_address[int'(gnt_id)*ADDR_W +: ADDR_W];
      ram_byteenable = req_byteenable[int'(gnt_id)*BE_W +: BE_W];
      ram_writedata  = req_writedata[int'(gnt_id)*DATA_W +: DATA_W];
    end
  end

  // Next-state for burst ownership and read-return tracking.
  always_comb begin
    owner_d   = owner_q;
    cnt_d     = CNT_W'(1);
    served_d  = gnt_vld;
    rd_pend_d = 1'b0;
    rd_id_d   = rd_id_q;
`ifdef PD_RAM_ARB_RR_EN
    last_d    = last_q;
`endif
    if (gnt_vld) begin
      owner_d   = gnt_id;
      rd_pend_d = ~req_write[gnt_id];
      rd_id_d   = gnt_id;
`ifdef PD_RAM_ARB_RR_EN
      last_d    = gnt_id;
`endif
      // Consecutive grant to the same owner extends the burst, saturating at the limit.
      if (served_q && (owner_q == gnt_id)) begin
        cnt_d = (cnt_q == CNT_W'(MAX_BURST)) ? cnt_q : cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers; an in-flight read is discarded by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_q   <= 1'b0;
      cnt_q     <= CNT_W'(1);
      served_q  <= 1'b0;
      rd_pend_q <= 1'b0;
      rd_id_q   <= 1'b0;
`ifdef PD_RAM_ARB_RR_EN
      last_q    <= 1'b1;
`endif
    end else begin
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      served_q  <= served_d;
      rd_pend_q <= rd_pend_d;
      rd_id_q   <= rd_id_d;
`ifdef PD_RAM_ARB_RR_EN
      last_q    <= last_d;
`endif
    end
  end

  // Read-return demux: RAM data is valid the cycle after the read was accepted.
  assign req_readdatavalid = {rd_pend_q & rd_id_q, rd_pend_q & ~rd_id_q};
  assign req_readdata      = rd_pend_q ? ram_readdata : '0;

endmodule

// File: tb/tb_pd_block_ram_arbiter.sv
// Self-checking bench for pd_block_ram_arbiter: behavioural RAM device plus a
// grant-history reference model (run lengths of consecutive grants).
module tb_pd_block_ram_arbiter;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int BW = 4;
`ifdef PD_RAM_ARB_RR_EN
  localparam int MB = 8;
`else
  localparam int MB = 4;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [1:0]    rd = '0;
  logic [1:0]    wr = '0;
  logic [2*AW-1:0] addr = '0;
  logic [2*BW-1:0] be = '0;
  logic [2*DW-1:0] wd = '0;

  logic [1:0]    req_waitrequest;
  logic [DW-1:0] req_readdata;
  logic [1:0]    req_readdatavalid;
  logic [AW-1:0] ram_address;
  logic [BW-1:0] ram_byteenable;
  logic          ram_chipselect;
  logic          ram_write;
  logic [DW-1:0] ram_writedata;
  logic          ram_clken;
  logic [DW-1:0] ram_readdata = '0;

  pd_block_ram_arbiter #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .BE_W      (BW),
    .MAX_BURST (MB)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .req_address       (addr),
    .req_byteenable    (be),
    .req_read          (rd),
    .req_write         (wr),
    .req_writedata     (wd),
    .req_waitrequest   (req_waitrequest),
    .req_readdata      (req_readdata),
    .req_readdatavalid (req_readdatavalid),
    .ram_address       (ram_address),
    .ram_byteenable    (ram_byteenable),
    .ram_chipselect    (ram_chipselect),
    .ram_write         (ram_write),
    .ram_writedata     (ram_writedata),
    .ram_clken         (ram_clken),
    .ram_readdata      (ram_readdata)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM: byte-enabled write at the edge, registered read.
  logic [DW-1:0] mem [0:4095] = '{default: '0};
  always @(posedge clk) begin
    if (ram_chipselect) begin
      if (ram_write) begin
        for (int b = 0; b < BW; b++)
          if (ram_byteenable[b]) mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
      end else begin
        ram_readdata <= mem[ram_address];
      end
    end
  end

  // Reference model state.
  logic [DW-1:0] ref_mem [0:4095] = '{default: '0};
  int            prev_g = -1;
  int            run = 0;
  int            last_g = 1;
  int            pend = 0;
  int            pend_id = 0;
  logic [DW-1:0] pend_data = '0;
  int            g = -1;

  logic [1:0]    exp_wait, obs_wait, exp_rv, obs_rv;
  logic [DW-1:0] exp_rdata, obs_rdata;
  logic [49:0]   exp_bus, obs_bus;
  logic          obs_clken;

  int checks = 0;
  int errors = 0;

  // One clock: sample mid-cycle, compute expectations from the model, advance the model.
  task automatic tick();
    int a;
    @(negedge clk);
    obs_wait  = req_waitrequest;
    obs_rv    = req_readdatavalid;
    obs_rdata = req_readdata;
    obs_bus   = {ram_chipselect, ram_write, ram_address, ram_byteenable, ram_writedata};
    obs_clken = ram_clken;
    if (!reset_n) begin
      exp_wait  = 2'b11;
      exp_rv    = 2'b00;
      exp_rdata = '0;
      exp_bus   = '0;
      g         = -1;
      prev_g    = -1;
      run       = 0;
      last_g    = 1;
      pend      = 0;
    end else begin
      if (!(rd[0] | wr[0]) && !(rd[1] | wr[1])) g = -1;
      else if (!(rd[1] | wr[1]))                g = 0;
      else if (!(rd[0] | wr[0]))                g = 1;
      else begin
`ifdef PD_RAM_ARB_RR_EN
        if (prev_g >= 0 && run < MB) g = prev_g;
        else if (prev_g >= 0)        g = 1 - prev_g;
        else                         g = 1 - last_g;
`else
        g = (prev_g == 0 && run >= MB) ? 1 : 0;
`endif
      end
      exp_wait = 2'b11;
      if (g >= 0) exp_wait[g] = 1'b0;
      exp_rv    = 2'b00;
      exp_rdata = '0;
      if (pend != 0) begin
        exp_rv[pend_id] = 1'b1;
        exp_rdata       = pend_data;
      end
      exp_bus = '0;
      if (g >= 0) exp_bus = {1'b1, wr[g], addr[g*AW +: AW], be[g*BW +: BW], wd[g*DW +: DW]};
      if (g >= 0) begin
        a = int'(addr[g*AW +: AW]);
        if (wr[g]) begin
          for (int b = 0; b < BW; b++)
            if (be[g*BW + b]) ref_mem[a][8*b +: 8] = wd[g*DW + 8*b +: 8];
          pend = 0;
        end else begin
          pend      = 1;
          pend_data = ref_mem[a];
        end
        pend_id = g;
        run     = (g == prev_g) ? run + 1 : 1;
        prev_g  = g;
        last_g  = g;
      end else begin
        pend   = 0;
        prev_g = -1;
        run    = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    rd = '0; wr = '0; addr = '0; be = '0; wd = '0;
  endtask

  task automatic drive_random(input int addr_max);
    rd   = 2'($urandom_range(0, 3));
    wr   = 2'($urandom_range(0, 3));
    addr = {12'($urandom_range(0, addr_max)), 12'($urandom_range(0, addr_max))};
    be   = 8'($urandom);
    wd   = {$urandom, $urandom};
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive_random(4095);
      tick();
      checks++;
      if (obs_wait !== 2'b11 || obs_rv !== 2'b00 || obs_rdata !== '0) begin
        errors++;
        $display("FAIL reset_outputs: got wait=%b rv=%b rdata=%h want wait=11 rv=00 rdata=0", obs_wait, obs_rv, obs_rdata);
      end
      checks++;
      if (obs_bus !== '0 || obs_clken !== 1'b1) begin
        errors++;
        $display("FAIL reset_ram: got bus=%h clken=%b want bus=0 clken=1", obs_bus, obs_clken);
      end
    end
    // Requester 1 reads 0x010, then reset hits while the data is due back.
    reset_n = 1'b1;
    drive_idle();
    rd[1] = 1'b1;
    addr[AW +: AW] = 12'h010;
    tick();
    checks++;
    if (obs_wait !== 2'b01) begin
      errors++;
      $display("FAIL reset_midread_accept: got wait=%b want 01", obs_wait);
    end
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive_random(4095);
      tick();
      checks++;
      if (obs_rv !== 2'b00 || obs_wait !== 2'b11 || obs_bus !== '0) begin
        errors++;
        $display("FAIL reset_midread_drop: got rv=%b wait=%b bus=%h want rv=00 wait=11 bus=0", obs_rv, obs_wait, obs_bus);
      end
    end
    // First cycle after release: requester 0 takes a tie.
    reset_n = 1'b1;
    drive_idle();
    rd = 2'b11;
    addr = {12'h020, 12'h021};
    tick();
    checks++;
    if (obs_wait !== 2'b10 || exp_wait !== 2'b10) begin
      errors++;
      $display("FAIL reset_release_tie: got wait=%b want 10", obs_wait);
    end
    drive_idle();
    tick();
  endtask

  task automatic test_single();
    drive_idle();
    wr[0] = 1'b1;
    addr[0 +: AW] = 12'h123;
    be[0 +: BW] = 4'b0011;
    wd[0 +: DW] = 32'hDEADBEEF;
    tick();
    checks++;
    if (obs_wait !== 2'b10 || obs_bus !== {1'b1, 1'b1, 12'h123, 4'b0011, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL single_write: got wait=%b bus=%h want wait=10 bus=%h", obs_wait, obs_bus, {1'b1, 1'b1, 12'h123, 4'b0011, 32'hDEADBEEF});
    end
    drive_idle();
    rd[0] = 1'b1;
    addr[0 +: AW] = 12'h123;
    tick();
    checks++;
    if (obs_wait !== 2'b10 || obs_rv !== 2'b00) begin
      errors++;
      $display("FAIL single_read_accept: got wait=%b rv=%b want wait=10 rv=00", obs_wait, obs_rv);
    end
    drive_idle();
    tick();
    checks++;
    if (obs_rv !== 2'b01 || obs_rdata !== 32'h0000BEEF) begin
      errors++;
      $display("FAIL single_read_return: got rv=%b rdata=%h want rv=01 rdata=0000beef", obs_rv, obs_rdata);
    end
  endtask

  task automatic test_contention();
    logic [1:0] want_wait;
    logic [1:0] prev_grant;
    reset_n = 1'b0;
    drive_idle();
    tick();
    reset_n = 1'b1;
    prev_grant = 2'b00;
    for (int k = 0; k < 4*MB + 3; k++) begin
      rd = 2'b11;
      wr = 2'b00;
      addr = {12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095))};
      be = 8'hFF;
      tick();
`ifdef PD_RAM_ARB_RR_EN
      want_wait = (((k / MB) % 2) == 1) ? 2'b01 : 2'b10;
`else
      want_wait = ((k % (MB + 1)) == MB) ? 2'b01 : 2'b10;
`endif
      checks++;
      if (obs_wait !== want_wait || obs_wait !== exp_wait) begin
        errors++;
        $display("FAIL contention_grant cyc %0d: got wait=%b want %b", k, obs_wait, want_wait);
      end
      checks++;
      if (obs_rv !== prev_grant || obs_rv !== exp_rv) begin
        errors++;
        $display("FAIL contention_rv cyc %0d: got rv=%b want %b", k, obs_rv, prev_grant);
      end
      if (exp_rv != 2'b00) begin
        checks++;
        if (obs_rdata !== exp_rdata) begin
          errors++;
          $display("FAIL contention_rdata cyc %0d: got %h want %h", k, obs_rdata, exp_rdata);
        end
      end
      prev_grant = ~want_wait;
    end
    drive_idle();
    tick();
  endtask

  task automatic test_back_to_back_raw();
    drive_idle();
    wr[1] = 1'b1;
    addr[AW +: AW] = 12'hFFF;
    be[BW +: BW] = 4'hF;
    wd[DW +: DW] = 32'h5A5A5A5A;
    tick();
    checks++;
    if (obs_wait !== 2'b01) begin
      errors++;
      $display("FAIL raw_write: got wait=%b want 01", obs_wait);
    end
    drive_idle();
    rd[0] = 1'b1;
    addr[0 +: AW] = 12'hFFF;
    tick();
    drive_idle();
    tick();
    checks++;
    if (obs_rv !== 2'b01 || obs_rdata !== 32'h5A5A5A5A) begin
      errors++;
      $display("FAIL raw_read: got rv=%b rdata=%h want rv=01 rdata=5a5a5a5a", obs_rv, obs_rdata);
    end
  endtask

  task automatic test_read_write_both();
    logic [DW-1:0] val;
    val = $urandom;
    drive_idle();
    rd[0] = 1'b1;
    wr[0] = 1'b1;
    addr[0 +: AW] = 12'h001;
    be[0 +: BW] = 4'hF;
    wd[0 +: DW] = val;
    tick();
    checks++;
    if (obs_wait !== 2'b10 || obs_bus[48] !== 1'b1) begin
      errors++;
      $display("FAIL rw_both_write: got wait=%b ram_write=%b want wait=10 ram_write=1", obs_wait, obs_bus[48]);
    end
    drive_idle();
    tick();
    checks++;
    if (obs_rv !== 2'b00) begin
      errors++;
      $display("FAIL rw_both_no_rv: got rv=%b want 00", obs_rv);
    end
    rd[0] = 1'b1;
    addr[0 +: AW] = 12'h001;
    tick();
    drive_idle();
    tick();
    checks++;
    if (obs_rv !== 2'b01 || obs_rdata !== val) begin
      errors++;
      $display("FAIL rw_both_readback: got rv=%b rdata=%h want rv=01 rdata=%h", obs_rv, obs_rdata, val);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      drive_random(15);
      tick();
      checks++;
      if (obs_wait !== exp_wait) begin
        errors++;
        $display("FAIL random_wait cyc %0d: got %b want %b", k, obs_wait, exp_wait);
      end
      checks++;
      if (obs_bus !== exp_bus) begin
        errors++;
        $display("FAIL random_ram cyc %0d: got %h want %h", k, obs_bus, exp_bus);
      end
      checks++;
      if (obs_rv !== exp_rv) begin
        errors++;
        $display("FAIL random_rv cyc %0d: got %b want %b", k, obs_rv, exp_rv);
      end
      if (exp_rv != 2'b00) begin
        checks++;
        if (obs_rdata !== exp_rdata) begin
          errors++;
          $display("FAIL random_rdata cyc %0d: got %h want %h", k, obs_rdata, exp_rdata);
        end
      end
    end
    drive_idle();
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_back_to_back_raw();
    test_read_write_both();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule

// File: doc/pd_block_ram_arbiter.md
# pd_block_ram_arbiter

Two-requester arbiter sharing the single-port 4096×32 on-chip RAM (byte-enabled, one-cycle read latency, unregistered output) between the host CPU data master (requester 0) and the CNN inference engine load/store port (requester 1). It sits between both Avalon-MM masters and the RAM's slave port inside the pd_block system. Accesses are granted per cycle, with bounded burst ownership and routed read-return. One access reaches the RAM per clock.

## Interface
- ADDR_W, 12, word address width (4096 words)
- DATA_W, 32, data width
- BE_W, DATA_W/8, byteenable width
- MAX_BURST, 8, max consecutive grants to one requester while the other waits (≥1)

Ports (req_* packed, index i = requester 0/1):
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- req_address  in  2×ADDR_W  word address per requester
- req_byteenable  in  2×BE_W  byte lanes per requester
- req_read  in  2  read request
- req_write  in  2  write request
- req_writedata  in  2×DATA_W  write data
- req_waitrequest  out  2  1 = request not accepted this cycle
- req_readdata  out  DATA_W  shared read-return data
- req_readdatavalid  out  2  read-return strobe per requester
- ram_address  out  ADDR_W  RAM address
- ram_byteenable  out  BE_W  RAM byte lanes
- ram_chipselect  out  1  RAM select
- ram_write  out  1  RAM write enable
- ram_writedata  out  DATA_W  RAM write data
- ram_clken  out  1  RAM clock enable, tied 1
- ram_readdata  in  DATA_W  RAM read data, valid the cycle after address

## Operation
- r[i] = req_read[i] | req_write[i]. Read and write both set: treated as write.
- Grant is combinational, one-hot or none:
  - r == 0: no grant.
  - Single requester active: that requester is granted.
  - Both active, with lock valid (owner served last cycle and cnt < MAX_BURST): owner is granted.
  - Both active, no lock: policy decides (see Configuration).
- Access is accepted when the grant is given. Then req_waitrequest[i] = ~grant[i] and the access is driven to the RAM the same cycle.
- Registers:
  - owner: last granted requester.
  - cnt: 1..MAX_BURST. Set to 1 on an owner change or after a no-grant cycle; increments on a consecutive grant to the same owner; saturates at MAX_BURST.
  - last: updated on every grant.
- cnt == MAX_BURST with the other requester active: the other requester wins next. Without contention, the owner keeps going indefinitely.
- Read return: an accepted read sets rd_pend/rd_id. On the next cycle, req_readdatavalid[rd_id] = 1 and req_readdata = ram_readdata. Back-to-back reads return every cycle, in order.
- RAM drive with no grant: ram_chipselect = 0, ram_write = 0, address/data/byteenable = 0.

## Timing
- Grant and waitrequest are combinational from req_read/req_write and the registered owner/cnt/last.
- Write latency: written at the accepting edge. Read latency: data returned 1 cycle after acceptance.
- Read-after-write to the same address in consecutive cycles by either requester: the read returns new data (the RAM writes at the earlier edge).
- Reset (reset_n low, any time):
  - req_waitrequest = 2'b11, forced.
  - req_readdatavalid = 0; req_readdata = 0.
  - All ram_* = 0, except ram_clken = 1.
  - owner = 0, cnt = 1, last = 1, rd_pend = 0. A read in flight is dropped, with no readdatavalid.
- First cycle after reset release: normal arbitration. Requester 0 wins a tie, since last = 1.

## Configuration
- PD_RAM_ARB_RR_EN defined: a tie without lock grants ~last (round-robin).
- PD_RAM_ARB_RR_EN undefined: a tie without lock always grants requester 0 (fixed priority). Burst limiting still applies: after MAX_BURST grants to 0, requester 1 gets exactly one grant before 0 regains priority.

## Structure
- Package pd_ram_arb_pkg:
  - ADDR_W/DATA_W defaults.
  - req_id_t (1-bit requester id).
  - NUM_REQ = 2.
- Sub-module pd_ram_arb_pick: combinational grant picker. Inputs: r, owner, cnt, last, MAX_BURST. Output: grant one-hot. Contains the RR/fixed ifdef.
- Top holds the owner/cnt/last/rd_pend registers, the RAM mux and the read-return demux.

## Test plan
- Reset mid-read: reset_n asserted the cycle after requester 1 reads addr 0x010 -> no readdatavalid; waitrequest = 11; all ram_* = 0 until release.
- Single requester: requester 0 writes 0xDEADBEEF to 0x123 with BE = 4'b0011, then reads 0x123 -> readdatavalid[0] one cycle later with data 0x0000BEEF (prior contents 0).
- Continuous contention, RR_EN, MAX_BURST = 8: both issue reads every cycle from reset -> grants alternate in runs of 8: 0×8, 1×8, and so on. readdatavalid matches each grant one cycle late.
- Fixed priority (macro undefined), MAX_BURST = 4: both stream reads -> grant pattern 0,0,0,0,1,0,0,0,0,1…
- Back-to-back RAW: requester 1 writes 0x5A5A5A5A to 0xFFF, and requester 0 reads 0xFFF the next cycle -> req_readdata = 0x5A5A5A5A with readdatavalid[0].
- Read+write asserted together by requester 0 at 0x001 -> treated as write; no readdatavalid; subsequent read returns the written data.
